// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 encodings, FSM state encoding and operand-sign decode helpers.
package muldiv_ctrl_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int FUNCT3_WIDTH   = 3;

   localparam logic [FUNCT3_WIDTH-1:0] MD_MUL    = 3'b000;
   localparam logic [FUNCT3_WIDTH-1:0] MD_MULH   = 3'b001;
   localparam logic [FUNCT3_WIDTH-1:0] MD_MULHSU = 3'b010;
   localparam logic [FUNCT3_WIDTH-1:0] MD_MULHU  = 3'b011;
   localparam logic [FUNCT3_WIDTH-1:0] MD_DIV    = 3'b100;
   localparam logic [FUNCT3_WIDTH-1:0] MD_DIVU   = 3'b101;
   localparam logic [FUNCT3_WIDTH-1:0] MD_REM    = 3'b110;
   localparam logic [FUNCT3_WIDTH-1:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   function automatic int md_cnt_width(input int xlen);
      return $clog2(xlen);
   endfunction

   function automatic logic md_rs1_signed(input logic [FUNCT3_WIDTH-1:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

   function automatic logic md_rs2_signed(input logic [FUNCT3_WIDTH-1:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_shift_core.sv
// Radix-2 datapath: one shift-add multiply step and one restoring divide
// step per enable, operating on unsigned operand magnitudes.
module md_shift_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] prod_o,
   output logic [XLEN-1:0]   quo_o,
   output logic [XLEN-1:0]   rem_o
);

   logic [2*XLEN-1:0] prod_q, prod_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN:0]     upper;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;

   // Both iterations advance together; the controller picks the field it needs.
   always_comb begin
      upper   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, b_q};
      prod_d  = prod_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      b_d     = b_q;
      if (load_i) begin
         prod_d = {{XLEN{1'b0}}, a_i};
         quo_d  = a_i;
         rem_d  = '0;
         b_d    = b_i;
      end else if (step_i) begin
         prod_d = {upper, prod_q[XLEN-1:1]};
         if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         b_q    <= '0;
      end else begin
         prod_q <= prod_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         b_q    <= b_d;
      end
   end

   assign prod_o = prod_q;
   assign quo_o  = quo_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter,
// divide-by-zero / overflow early exit and final sign correction.
//
// state   | meaning
// IDLE    | waiting for start; special cases resolved here
// CALC    | one radix-2 iteration per cycle, XLEN cycles
// FIX     | sign correction and field select into md_result
// DONE    | done pulse, result valid
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = REG_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    kill,
   input  logic [FUNCT3_WIDTH-1:0] funct3,
   input  logic [XLEN-1:0]         read_data1,
   input  logic [XLEN-1:0]         read_data2,
   output logic                    busy,
   output logic                    stall,
   output logic                    done,
   output logic [XLEN-1:0]         md_result
);

   localparam int              CNT_W   = md_cnt_width(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [FUNCT3_WIDTH-1:0] f3_q, f3_d;
   logic                    s1_q, s1_d, s2_q, s2_d;
   logic [XLEN-1:0]         res_q, res_d;
   logic                    core_load, core_step;
   logic [2*XLEN-1:0]       prod, prod_fix;
   logic [XLEN-1:0]         quo, rem, quo_fix, rem_fix, fix_result;
   logic [XLEN-1:0]         mag1, mag2;
   logic                    neg1, neg2, div_zero, sgn_ovf;

   assign neg1     = md_rs1_signed(funct3) & read_data1[XLEN-1];
   assign neg2     = md_rs2_signed(funct3) & read_data2[XLEN-1];
   assign mag1     = neg1 ? (~read_data1 + 1'b1) : read_data1;
   assign mag2     = neg2 ? (~read_data2 + 1'b1) : read_data2;
   assign div_zero = funct3[2] & (read_data2 == '0);
   assign sgn_ovf  = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                     (read_data1 == MIN_NEG) && (read_data2 == '1);

   md_shift_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load_i (core_load),
      .step_i (core_step),
      .a_i    (mag1),
      .b_i    (mag2),
      .prod_o (prod),
      .quo_o  (quo),
      .rem_o  (rem)
   );

   // Unsigned flavours latch zero sign flags, so no correction applies to them.
   assign prod_fix = (s1_q ^ s2_q) ? (~prod + 1'b1) : prod;
   assign quo_fix  = (s1_q ^ s2_q) ? (~quo + 1'b1) : quo;
   assign rem_fix  = s1_q ? (~rem + 1'b1) : rem;

   always_comb begin
      fix_result = rem_fix;
      case (f3_q)
         MD_MUL:                       fix_result = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fix_result = quo_fix;
         MD_REM, MD_REMU:              fix_result = rem_fix;
         default:                      fix_result = rem_fix;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      res_d     = res_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start && !kill) begin
               f3_d  = funct3;
               s1_d  = neg1;
               s2_d  = neg2;
               cnt_d = '0;
               if (div_zero) begin
                  state_d = MD_DONE;
                  res_d   = funct3[1] ? read_data1 : '1;
               end else if (sgn_ovf) begin
                  state_d = MD_DONE;
                  res_d   = funct3[1] ? '0 : MIN_NEG;
               end else begin
                  state_d   = MD_CALC;
                  core_load = 1'b1;
               end
            end
         end
         MD_CALC: begin
            core_step = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) state_d = MD_FIX;
         end
         MD_FIX: begin
            res_d   = fix_result;
            state_d = MD_DONE;
         end
         MD_DONE:  state_d = MD_IDLE;
         default:  state_d = MD_IDLE;
      endcase
      if (kill && (state_q != MD_IDLE)) begin
         state_d   = MD_IDLE;
         res_d     = res_q;
         core_step = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         res_q   <= res_d;
      end
   end

   assign busy      = (state_q != MD_IDLE);
   assign done      = (state_q == MD_DONE) & ~kill;
   assign stall     = busy | (start & ~kill & (state_q == MD_IDLE));
   assign md_result = res_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed vectors push expected result and
// latency; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] rd1 = '0;
   logic [31:0] rd2 = '0;
   logic        busy, stall, done;
   logic [31:0] md_result;

   muldiv_ctrl #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .kill       (kill),
      .funct3     (funct3),
      .read_data1 (rd1),
      .read_data2 (rd2),
      .busy       (busy),
      .stall      (stall),
      .done       (done),
      .md_result  (md_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      int          t0;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with result %h, expected no done", md_result);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, md_result, e.res);
            chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            chk({e.name, "_busy_stall"}, {30'd0, busy, stall}, 32'd3);
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat, input string name);
      @(negedge clk);
      funct3 = f;
      rd1    = a;
      rd2    = b;
      start  = 1'b1;
      sb.push_back('{res: r, t0: cyc, lat: lat, name: name});
      #1 chk({name, "_stall_start"}, {31'd0, stall}, 32'd1);
      @(negedge clk);
      start  = 1'b0;
      funct3 = ~f;
      rd1    = ~a;
      rd2    = ~b;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(negedge clk);
         #2;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input int lat, input string name);
      issue(f, a, b, r, lat, name);
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", {28'd0, busy, done, stall, 1'b0}, 32'd0);
      chk("reset_result", md_result, 32'd0);
      rst = 1'b0;

      run(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ones");
      run(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, "mul_ones");
      run(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div_m7_2");
      run(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem_m7_2");
      run(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu_m1_2");
      run(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
      run(MD_REM,    32'd5,         32'd0,         32'd5,         1,  "rem_by0");
      run(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
      run(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");
      run(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min_min");
      run(MD_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
      run(MD_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34, "rem_7_m2");
      run(MD_REMU,   32'd100,       32'd7,         32'd2,         34, "remu_100_7");

      // kill at CALC count 10: no done, md_result keeps 2
      @(negedge clk);
      funct3 = MD_MUL;
      rd1    = 32'd9;
      rd2    = 32'd9;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_result_kept", md_result, 32'd2);
      kill = 1'b0;
      run(MD_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 34, "mulh_after_kill");
      run(MD_MUL,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 34, "mul_m3_5");

      // start held through the whole operation: exactly one result
      @(negedge clk);
      funct3 = MD_DIVU;
      rd1    = 32'd100;
      rd2    = 32'd7;
      start  = 1'b1;
      sb.push_back('{res: 32'd14, t0: cyc, lat: 34, name: "divu_held"});
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         @(negedge clk);
         #2;
      end
      start = 1'b0;
      wait_done("divu_held");
      repeat (5) @(negedge clk);
      chk("held_single_op_busy", {31'd0, busy}, 32'd0);

      // start and kill together in IDLE
      @(negedge clk);
      funct3 = MD_MUL;
      rd1    = 32'd3;
      rd2    = 32'd3;
      start  = 1'b1;
      kill   = 1'b1;
      #1 chk("start_kill_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      chk("start_kill_busy", {31'd0, busy}, 32'd0);
      chk("start_kill_result", md_result, 32'd14);

      // asynchronous reset mid-CALC
      @(negedge clk);
      funct3 = MD_DIV;
      rd1    = 32'd1000;
      rd2    = 32'd3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_flags", {29'd0, busy, done, stall}, 32'd0);
      chk("rst_async_result", md_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run(MD_MUL, 32'd3, 32'd4, 32'd12, 34, "mul_3_4_after_rst");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
